// File: rtl/divider_8bit.sv
// Sequential restoring divider: loads a dividend into Q, then divides it by a latched
// divisor one quotient bit per SHIFT/SUB pair, driving R/Q onto 7-segment displays.
module divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute_h,
    input  logic             ClearA_LoadB_h,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Rval,
    output logic [WIDTH-1:0] Qval,
    output logic             Done,
    output logic             DivZero,
    output logic [6:0]       RhexU,
    output logic [6:0]       RhexL,
    output logic [6:0]       QhexU,
    output logic [6:0]       QhexL
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (WIDTH < 8) ? WIDTH : 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SUB   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH:0]   r_r, r_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [WIDTH-1:0] d_r, d_s;
    logic [CW-1:0]    count_r, count_s;
    logic             done_r, done_s;
    logic             divzero_r, divzero_s;

    logic [2*WIDTH:0] rq_shift_s;
    logic [WIDTH+1:0] diff_s;
    logic [7:0]       r_disp_s;
    logic [7:0]       q_disp_s;

    // Active-low 7-segment pattern (gfedcba) for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Datapath helpers: joint left shift of {R,Q} and the trial subtraction (sign in MSB).
    always_comb begin
        rq_shift_s = {r_r, q_r} << 1;
        diff_s     = {1'b0, r_r} - {2'b00, d_r};
    end

    // Next-state and next-register logic for the divider FSM.
    always_comb begin
        state_s   = state_r;
        r_s       = r_r;
        q_s       = q_r;
        d_s       = d_r;
        count_s   = count_r;
        done_s    = done_r;
        divzero_s = divzero_r;
        case (state_r)
            ST_IDLE: begin
                if (ClearA_LoadB_h) begin
                    r_s       = {(WIDTH+1){1'b0}};
                    q_s       = SW;
                    done_s    = 1'b0;
                    divzero_s = 1'b0;
                    state_s   = ST_IDLE;
                end else if (Execute_h) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                d_s     = SW;
                count_s = {CW{1'b0}};
                if (SW == {WIDTH{1'b0}}) begin
                    // Divide-by-zero aborts straight to HOLD with R/Q untouched.
                    divzero_s = 1'b1;
                    done_s    = 1'b1;
                    state_s   = ST_HOLD;
                end else begin
                    divzero_s = 1'b0;
                    done_s    = 1'b0;
                    r_s       = {(WIDTH+1){1'b0}};
                    state_s   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                r_s     = rq_shift_s[2*WIDTH:WIDTH];
                q_s     = rq_shift_s[WIDTH-1:0];
                state_s = ST_SUB;
            end
            ST_SUB: begin
                if (!diff_s[WIDTH+1]) begin
                    r_s    = diff_s[WIDTH:0];
                    q_s[0] = 1'b1;
                end else begin
                    q_s[0] = 1'b0;
                end
                count_s = count_r + CW'(1);
                if (count_r == CW'(WIDTH - 1)) begin
                    done_s  = 1'b1;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                done_s = 1'b1;
                if (Execute_h) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any division in progress.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            r_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            d_r       <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            done_r    <= 1'b0;
            divzero_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            r_r       <= r_s;
            q_r       <= q_s;
            d_r       <= d_s;
            count_r   <= count_s;
            done_r    <= done_s;
            divzero_r <= divzero_s;
        end
    end

    assign Rval    = r_r[WIDTH-1:0];
    assign Qval    = q_r;
    assign Done    = done_r;
    assign DivZero = divzero_r;

    // Display decode of the low byte of R and Q.
    always_comb begin
        r_disp_s = 8'(r_r[DW-1:0]);
        q_disp_s = 8'(q_r[DW-1:0]);
        RhexU    = seg7(r_disp_s[7:4]);
        RhexL    = seg7(r_disp_s[3:0]);
        QhexU    = seg7(q_disp_s[7:4]);
        QhexL    = seg7(q_disp_s[3:0]);
    end

endmodule

// File: tb/tb_divider_8bit.sv
// Directed bench for divider_8bit: an arithmetic reference model of R/Q/Done/DivZero
// checked every cycle while idle/holding, plus literal results and latency checks.
module tb_divider_8bit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Execute_h;
    logic       ClearA_LoadB_h;
    logic [7:0] SW;
    logic [7:0] Rval, Qval;
    logic       Done, DivZero;
    logic [6:0] RhexU, RhexL, QhexU, QhexL;

    int n_vec  = 0;
    int n_miss = 0;
    bit check_en = 1'b0;

    logic [7:0] m_q, m_r;
    logic       m_done, m_dz;

    divider_8bit #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Execute_h(Execute_h), .ClearA_LoadB_h(ClearA_LoadB_h),
        .SW(SW), .Rval(Rval), .Qval(Qval), .Done(Done), .DivZero(DivZero),
        .RhexU(RhexU), .RhexL(RhexL), .QhexU(QhexU), .QhexL(QhexL)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model while outputs are meaningful.
    always @(negedge Clk) begin
        if (check_en) begin
            chk("Qval", Qval, m_q);
            chk("Rval", Rval, m_r);
            chk("Done", {7'd0, Done}, {7'd0, m_done});
            chk("DivZero", {7'd0, DivZero}, {7'd0, m_dz});
            chk("QhexU", {1'b0, QhexU}, {1'b0, seg(m_q[7:4])});
            chk("QhexL", {1'b0, QhexL}, {1'b0, seg(m_q[3:0])});
            chk("RhexU", {1'b0, RhexU}, {1'b0, seg(m_r[7:4])});
            chk("RhexL", {1'b0, RhexL}, {1'b0, seg(m_r[3:0])});
        end
    end

    task automatic model_reset();
        m_q = 8'h00; m_r = 8'h00; m_done = 1'b0; m_dz = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] sw);
        ClearA_LoadB_h = 1'b1;
        SW = sw;
        @(posedge Clk); #1;
        ClearA_LoadB_h = 1'b0;
        m_q = sw; m_r = 8'h00; m_done = 1'b0; m_dz = 1'b0;
    endtask

    // Run one division; SW is scrambled once D is latched and ClearA may be pulsed mid-run.
    task automatic do_exec(input logic [7:0] sw, input int hold, input int pulse_at);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        check_en = 1'b0;
        Execute_h = 1'b1;
        SW = sw;
        while (n < 100 && !got) begin
            @(posedge Clk); #1;
            n++;
            if (Done && n >= 2) begin
                got = 1'b1;
            end else begin
                if (n == 2) SW = 8'h03;
                if (n == pulse_at) begin ClearA_LoadB_h = 1'b1; SW = 8'hAA; end
                if (n == pulse_at + 1) ClearA_LoadB_h = 1'b0;
            end
        end
        ClearA_LoadB_h = 1'b0;
        chk("latency", 8'(n), (sw == 8'h00) ? 8'd2 : 8'd18);
        if (sw == 8'h00) begin
            m_dz = 1'b1;
        end else begin
            m_r = m_q % sw;
            m_q = m_q / sw;
            m_dz = 1'b0;
        end
        m_done = 1'b1;
        check_en = 1'b1;
        repeat (hold) @(posedge Clk);
        #1 Execute_h = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " Qval"}, Qval, 8'h00);
        chk({tag, " Rval"}, Rval, 8'h00);
        chk({tag, " Done"}, {7'd0, Done}, 8'h00);
        chk({tag, " DivZero"}, {7'd0, DivZero}, 8'h00);
        chk({tag, " QhexL"}, {1'b0, QhexL}, 8'h40);
        chk({tag, " RhexU"}, {1'b0, RhexU}, 8'h40);
    endtask

    initial begin
        Reset = 1'b0; Execute_h = 1'b0; ClearA_LoadB_h = 1'b0; SW = 8'h00;
        model_reset();
        check_en = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        chk_zero("reset");

        // Basic division with the documented 18-cycle latency.
        do_load(8'hC5);
        do_exec(8'h07, 0, 0);
        chk("T2 Q", Qval, 8'h1C);
        chk("T2 R", Rval, 8'h01);

        // Divisor of one, and divisor larger than dividend.
        do_load(8'hFF);
        do_exec(8'h01, 0, 0);
        chk("T3a Q", Qval, 8'hFF);
        chk("T3a R", Rval, 8'h00);
        do_load(8'h05);
        do_exec(8'h09, 0, 0);
        chk("T3b Q", Qval, 8'h00);
        chk("T3b R", Rval, 8'h05);

        // Divide by zero.
        do_load(8'hC5);
        do_exec(8'h00, 0, 0);
        chk("T4 DivZero", {7'd0, DivZero}, 8'h01);
        chk("T4 Q", Qval, 8'hC5);
        chk("T4 R", Rval, 8'h00);

        // Held Execute runs once; re-press divides the previous quotient.
        do_load(8'hC5);
        do_exec(8'h07, 40, 0);
        chk("T5a Q", Qval, 8'h1C);
        do_exec(8'h04, 0, 0);
        chk("T5b Q", Qval, 8'h07);
        chk("T5b R", Rval, 8'h00);

        // Asynchronous reset mid-idle with nonzero R/Q.
        do_load(8'hC5);
        do_exec(8'h07, 0, 0);
        @(posedge Clk); #3;
        Reset = 1'b0;
        model_reset();
        #1 chk_zero("T1 async");
        @(posedge Clk); #1 Reset = 1'b1;

        // ClearA pulse during SUB is ignored.
        do_load(8'hC5);
        do_exec(8'h07, 0, 5);
        chk("T6a Q", Qval, 8'h1C);
        chk("T6a R", Rval, 8'h01);

        // Reset in the middle of a run leaves nothing behind.
        do_load(8'h64);
        check_en = 1'b0;
        Execute_h = 1'b1;
        SW = 8'h0A;
        repeat (8) @(posedge Clk);
        #1 Reset = 1'b0;
        Execute_h = 1'b0;
        model_reset();
        #1 chk_zero("T6 abort");
        check_en = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        chk_zero("T6 after");
        do_load(8'h64);
        do_exec(8'h0A, 0, 0);
        chk("T6b Q", Qval, 8'h0A);
        chk("T6b R", Rval, 8'h00);

        repeat (3) @(posedge Clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
